// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch FIFO between the PC stage and decode, with flush and sticky overflow.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic [31:0]      imemaddr,
    input  logic [31:0]      imemload,
    input  logic             flush,
    input  logic             deq,
    output logic             imemREN,
    output logic             q_valid,
    output logic [31:0]      q_instr,
    output logic [31:0]      q_pc,
    output logic [31:0]      q_npc,
    output logic [PTR_W:0]   q_count,
    output logic             q_full,
    output logic             q_ovf
);
    logic [31:0]      instr_m [DEPTH];
    logic [31:0]      pc_m    [DEPTH];
    logic [31:0]      npc_m   [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             held, byp, pop, enq;

    always_comb begin
        held = q_count != '0;
`ifdef FETCH_BYPASS_EN
        byp = !held && ihit && !flush;
`else
        byp = 1'b0;
`endif
        q_full  = q_count == (PTR_W+1)'(DEPTH);
        imemREN = !q_full && !flush;
        q_valid = held || byp;
        pop     = held && deq;
        // a bypassed word taken by decode the same cycle never touches storage
        enq     = ihit && !flush && (!q_full || pop) && !(byp && deq);
        q_instr = held ? instr_m[rd_ptr] : byp ? imemload : '0;
        q_pc    = held ? pc_m[rd_ptr]    : byp ? imemaddr : '0;
        q_npc   = held ? npc_m[rd_ptr]   : byp ? imemaddr + 32'd4 : '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
            q_ovf   <= 1'b0;
        end else begin
            if (ihit && q_full && !pop && !flush)
                q_ovf <= 1'b1;
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                q_count <= '0;
            end else begin
                if (enq)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (enq != pop)
                    q_count <= enq ? q_count + (PTR_W+1)'(1) : q_count - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            instr_m[wr_ptr] <= imemload;
            pc_m[wr_ptr]    <= imemaddr;
            npc_m[wr_ptr]   <= imemaddr + 32'd4;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a queue-based reference model checked every cycle.
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0, nRST = 1'b0;
    logic        ihit = 1'b0, flush = 1'b0, deq = 1'b0;
    logic [31:0] imemaddr = '0, imemload = '0;
    logic        imemREN, q_valid, q_full, q_ovf;
    logic [31:0] q_instr, q_pc, q_npc;
    logic [2:0]  q_count;

    int n_checks = 0, n_fail = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemaddr(imemaddr), .imemload(imemload),
        .flush(flush), .deq(deq), .imemREN(imemREN), .q_valid(q_valid), .q_instr(q_instr),
        .q_pc(q_pc), .q_npc(q_npc), .q_count(q_count), .q_full(q_full), .q_ovf(q_ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {logic [31:0] i; logic [31:0] p;} ent_t;
    ent_t mq[$];
    bit   m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // reference: a plain FIFO of {instr, pc} updated by the handshake rules
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mq.delete();
            m_ovf <= 1'b0;
        end else if (!flush) begin
            automatic bit full = mq.size() == DEPTH;
            automatic bit popm = mq.size() > 0 && deq;
            automatic bit bypass = BYP && mq.size() == 0 && ihit;
            if (!(bypass && deq)) begin
                if (ihit && full && !popm) m_ovf <= 1'b1;
                if (popm) void'(mq.pop_front());
                if (ihit && (!full || popm)) mq.push_back('{imemload, imemaddr});
            end
        end else begin
            mq.delete();
        end
    end

    always @(negedge CLK) begin
        automatic bit bypass = BYP && mq.size() == 0 && ihit && !flush;
        automatic logic [31:0] ei = mq.size() > 0 ? mq[0].i : bypass ? imemload : 32'd0;
        automatic logic [31:0] ep = mq.size() > 0 ? mq[0].p : bypass ? imemaddr : 32'd0;
        automatic logic [31:0] en = (mq.size() > 0 || bypass) ? ep + 32'd4 : 32'd0;
        check("valid", {31'd0, q_valid}, {31'd0, mq.size() > 0 || bypass});
        check("count", {29'd0, q_count}, mq.size());
        check("full", {31'd0, q_full}, {31'd0, mq.size() == DEPTH});
        check("imemREN", {31'd0, imemREN}, {31'd0, mq.size() != DEPTH && !flush});
        check("instr", q_instr, ei);
        check("pc", q_pc, ep);
        check("npc", q_npc, en);
        check("ovf", {31'd0, q_ovf}, {31'd0, m_ovf});
    end

    task automatic step(input bit h, input logic [31:0] a, input logic [31:0] l, input bit f, input bit d);
        ihit = h; imemaddr = a; imemload = l; flush = f; deq = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1'b0; flush = 1'b0; deq = 1'b0;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        idle();
        check("rst_count", {29'd0, q_count}, 32'd0);
        check("rst_valid", {31'd0, q_valid}, 32'd0);
        check("rst_instr", q_instr, 32'd0);
        check("rst_ovf", {31'd0, q_ovf}, 32'd0);

        step(1, 32'h0, 32'hA, 0, 0);
        step(1, 32'h4, 32'hB, 0, 0);
        step(1, 32'h8, 32'hC, 0, 0);
        idle();
        check("t1_count", {29'd0, q_count}, 32'd3);
        check("t1_pc", q_pc, 32'h0);
        check("t1_npc", q_npc, 32'h4);
        check("t1_instr", q_instr, 32'hA);

        step(1, 32'hC, 32'hD, 0, 0);
        idle();
        check("t2_full", {31'd0, q_full}, 32'd1);
        check("t2_ren", {31'd0, imemREN}, 32'd0);
        step(1, 32'h10, 32'hE, 0, 1);
        idle();
        check("t2_count", {29'd0, q_count}, 32'd4);
        check("t2_head", q_instr, 32'hB);
        repeat (3) step(0, 32'h0, 32'h0, 0, 1);
        idle();
        check("t2_tail", q_instr, 32'hE);
        check("t2_tailpc", q_pc, 32'h10);
        step(0, 32'h0, 32'h0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 1);

        for (int i = 0; i < 3; i++) step(1, 32'h20 + 4 * i, 32'h1 + i, 0, 0);
        step(1, 32'h2C, 32'hDEAD, 1, 1);
        idle();
        check("t3_count", {29'd0, q_count}, 32'd0);
        check("t3_valid", {31'd0, q_valid}, 32'd0);
        check("t3_instr", q_instr, 32'd0);

        for (int i = 0; i < 4; i++) step(1, 32'h40 + 4 * i, 32'h10 + i, 0, 0);
        step(1, 32'h50, 32'h99, 0, 0);
        idle();
        check("t4_ovf", {31'd0, q_ovf}, 32'd1);
        check("t4_count", {29'd0, q_count}, 32'd4);
        check("t4_head", q_instr, 32'h10);
        step(0, 32'h0, 32'h0, 1, 0);
        idle();
        check("t4_ovf_flush", {31'd0, q_ovf}, 32'd1);
        step(1, 32'h60, 32'h20, 0, 0);
        step(1, 32'h64, 32'h21, 0, 0);
        idle();
        nRST = 1'b0;
        #1;
        check("t4_rst_ovf", {31'd0, q_ovf}, 32'd0);
        check("t4_rst_count", {29'd0, q_count}, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        step(1, 32'h70, 32'h30, 0, 0);
        idle();
        check("t4_post", q_instr, 32'h30);

        step(0, 32'h0, 32'h0, 0, 1);
        step(1, 32'hFFFF_FFF0, 32'h100, 0, 0);
        for (int i = 1; i < 10; i++) begin
            step(1, 32'hFFFF_FFF0 + 4 * i, 32'h100 + i, 0, 1);
            if (i == 3) begin
                idle();
                check("t5_pc", q_pc, 32'hFFFF_FFFC);
                check("t5_npc", q_npc, 32'h0);
            end
        end
        idle();
        check("t5_last", q_instr, 32'h109);
        step(0, 32'h0, 32'h0, 0, 1);

        ihit = 1'b1; deq = 1'b1; flush = 1'b0; imemaddr = 32'h80; imemload = 32'h1234;
        #2;
        check("t6_valid", {31'd0, q_valid}, {31'd0, BYP});
        check("t6_instr", q_instr, BYP ? 32'h1234 : 32'h0);
        @(posedge CLK);
        #1;
        idle();
        check("t6_count", {29'd0, q_count}, BYP ? 32'd0 : 32'd1);
        check("t6_next_valid", {31'd0, q_valid}, BYP ? 32'd0 : 32'd1);
        step(0, 32'h0, 32'h0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue directly downstream of the program counter stage.
- Captures each returned instruction word together with the instruction address that fetched it and that address + 4.
- Buffers these entries in a small FIFO and hands them to decode under a valid/ready handshake.
- Throttles instruction reads when full and discards all buffered work on a control-flow redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction memory returned valid data this cycle.
- imemaddr  input  32  instruction address currently presented by the PC stage.
- imemload  input  32  instruction word returned by memory.
- flush  input  1  redirect (branch/jump taken); discard queue contents.
- deq  input  1  decode consumes the head entry.
- imemREN  output  1  instruction read enable to memory.
- q_valid  output  1  head entry valid.
- q_instr  output  32  head instruction.
- q_pc  output  32  address of head instruction.
- q_npc  output  32  head address + 4.
- q_count  output  PTR_W+1  entries held.
- q_full  output  1  q_count == DEPTH.
- q_ovf  output  1  sticky overflow error.

Behaviour:
- Reset (nRST low, asynchronous):
  - Read and write pointers 0; q_count 0; q_valid 0.
  - q_instr, q_pc, q_npc all 0; q_ovf 0.
  - Storage contents are don't-care.
- Control signals:
  - imemREN = !q_full && !flush (combinational).
  - enq = ihit && !flush && (!q_full || pop).
  - pop = q_valid && deq.
- Enqueue: on a rising edge with enq, write {imemload, imemaddr, imemaddr+4} at the write pointer and advance the write pointer modulo DEPTH.
- Dequeue: on a rising edge with pop, advance the read pointer modulo DEPTH.
- Simultaneous push and pop:
  - q_count is unchanged.
  - Allowed even when full; the popped slot is reused the same edge.
- Pop on empty: deq with q_valid=0 is ignored; no state change.
- Flush:
  - On a rising edge with flush, both pointers and q_count go to 0, regardless of ihit or deq.
  - Any same-cycle ihit data is dropped.
  - Takes priority over enqueue and dequeue.
- Outputs:
  - q_valid = (q_count != 0).
  - q_instr, q_pc, q_npc reflect the entry at the read pointer when q_valid, else 0.
  - Read is combinational from storage, so an entry is visible the cycle after its enqueue edge.
  - Minimum fetch-to-decode latency is 1 cycle.
- Arithmetic: q_npc computed as unsigned 32-bit add; 0xFFFFFFFC yields 0x00000000.
- Overflow: ihit && q_full && !pop && !flush sets q_ovf on that edge. The data is dropped and q_ovf stays set until reset.
- Pointer wrap: pointers wrap DEPTH-1 -> 0. Full and empty are distinguished by q_count, not by pointer equality.
- Mid-operation reset: all state clears immediately on nRST fall; the first post-reset entry lands in slot 0.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when q_count == 0 and ihit && !flush, the q_* outputs present imemload/imemaddr/imemaddr+4 combinationally and q_valid=1.
  - If deq is also high that cycle, the entry is consumed without being written (pointers and count unchanged).
  - Otherwise it is enqueued normally.
- Undefined: no bypass; the empty-queue ihit is enqueued and visible one cycle later.

Test Plan:
- Reset, then ihit for 3 cycles with imemaddr 0x0,0x4,0x8 and imemload 0xA,0xB,0xC, deq=0 -> q_count=3; head q_pc=0x0, q_npc=0x4, q_instr=0xA.
- Fill DEPTH=4 entries -> q_full=1, imemREN=0. Then ihit and deq together -> q_count stays 4, new tail written, head advances.
- Three entries held, then flush with ihit=1 and deq=1 -> next cycle q_count=0, q_valid=0. The dropped word is never seen on q_instr.
- Full, ihit=1, deq=0 -> q_ovf=1 and q_count=4. q_ovf stays 1 across a later flush and clears only on nRST.
- Push/pop 10 entries with imemaddr starting at 0xFFFFFFF0 -> FIFO order preserved through pointer wrap. Entry 0xFFFFFFFC has q_npc=0x0.
- With FETCH_BYPASS_EN: empty queue, ihit=1, deq=1, imemload=0x1234 -> same-cycle q_valid=1, q_instr=0x1234; next cycle q_count=0. Without the macro: q_valid=0 that cycle, 1 the next.
